// File: rtl/jk_bank_pkg.sv
// Shared opcode encodings, controller state type and default bank width for the JK bank controller.
package jk_bank_pkg;

    localparam int W_DEF = 4;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_CNT_UP = 2'b10,
        OP_CNT_DN = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_cnt(input op_e o);
        return (o == OP_CNT_UP) || (o == OP_CNT_DN);
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop: set, clear, toggle or hold on each rising edge; async active-low reset to 0.
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b10:   q <= 1'b1;
                2'b01:   q <= 1'b0;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command FSM driving a W-bit bank of JK cells: LOAD/CLEAR in one step, CNT_UP/CNT_DN in N steps.
// An accepted command is registered for one cycle before it acts, so q changes from accept+2 at the earliest.
module jk_bank_ctrl
    import jk_bank_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_arg,
    output logic         busy,
    output logic         done,
    output logic         wrap,
    output logic [W-1:0] q
);

    state_e       state;
    op_e          op;
    logic         pend;
    logic [W-1:0] arg;
    logic [W-1:0] rem;
    logic         wrap_acc;

    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] qbar;
    logic [W-1:0] up_tgl;
    logic [W-1:0] dn_tgl;
    logic         step_wrap;
    logic         accept;

    assign accept = cmd_valid && cmd_ready;

    // Bit i toggles when every lower bit is 1 (up) or 0 (down); bit 0 always toggles.
    assign up_tgl[0] = 1'b1;
    assign dn_tgl[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 1; gi < W; gi++) begin : g_chain
            assign up_tgl[gi] = &q[gi-1:0];
            assign dn_tgl[gi] = &qbar[gi-1:0];
        end
        for (gi = 0; gi < W; gi++) begin : g_cell
            jk_cell u_cell (
                .clk  (clk),
                .reset(reset),
                .j    (j[gi]),
                .k    (k[gi]),
                .q    (q[gi]),
                .qbar (qbar[gi])
            );
        end
    endgenerate

    always_comb begin
        j         = '0;
        k         = '0;
        step_wrap = 1'b0;
        if (state == ST_EXEC) begin
            case (op)
                OP_LOAD: begin
                    j = arg & qbar;
                    k = ~arg & q;
                end
                OP_CLEAR: begin
                    k = q;
                end
                OP_CNT_UP: begin
                    j         = up_tgl;
                    k         = up_tgl;
                    step_wrap = &q;
                end
                default: begin
                    j         = dn_tgl;
                    k         = dn_tgl;
                    step_wrap = &qbar;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            op        <= OP_LOAD;
            pend      <= 1'b0;
            arg       <= '0;
            rem       <= '0;
            wrap_acc  <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pend) begin
                        pend <= 1'b0;
                        // Zero-step counts finish without touching the bank.
                        if (is_cnt(op) && (rem == '0)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end else if (accept) begin
                        pend      <= 1'b1;
                        op        <= op_e'(cmd_op);
                        arg       <= cmd_arg;
                        rem       <= is_cnt(op_e'(cmd_op)) ? cmd_arg : '0;
                        wrap_acc  <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    wrap_acc <= wrap_acc | step_wrap;
                    if (is_cnt(op)) begin
                        rem <= rem - W'(1);
                    end
                    if (!is_cnt(op) || (rem == W'(1))) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        wrap  <= wrap_acc | step_wrap;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/jk_bank_ctrl.md
JK_BANK_CTRL -- requirements
Module: jk_bank_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning the number of JK flip-flop bits in the controlled bank (W >= 2).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command offered by the requester.
REQ-005 cmd_ready  output  1  controller accepts a command; high only in IDLE.
REQ-006 cmd_op  input  2  opcode: 00 LOAD, 01 CLEAR, 10 CNT_UP, 11 CNT_DN.
REQ-007 cmd_arg  input  W  LOAD value or step count N for CNT_UP/CNT_DN; ignored for CLEAR.
REQ-008 busy  output  1  high in EXEC and DONE.
REQ-009 done  output  1  one-cycle pulse in DONE.
REQ-010 wrap  output  1  valid with done; high if any step of the command wrapped modulo 2^W.
REQ-011 q  output  W  current bank contents.

Function
REQ-012 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both high; cmd_op and cmd_arg are captured at that edge.
REQ-013 The FSM SHALL have three states: IDLE, EXEC, DONE.
- IDLE -> EXEC on accept, unless the command is CNT_UP/CNT_DN with N=0.
- IDLE -> DONE on accept of CNT_UP/CNT_DN with N=0; q is unchanged and wrap=0.
- EXEC -> DONE after the last step.
- DONE -> IDLE unconditionally.
REQ-014 cmd_valid outside IDLE SHALL be ignored; the requester holds it until cmd_ready is high.
REQ-015 The bank SHALL change only through per-bit j/k drive from the controller: j=1,k=0 sets; j=0,k=1 clears; j=k=1 toggles; j=k=0 holds.
REQ-016 In EXEC, j/k SHALL be driven as follows; outside EXEC, j=k=0.
- LOAD: j = arg & ~q; k = ~arg & q.
- CLEAR: j = 0; k = q.
REQ-017 LOAD and CLEAR SHALL occupy exactly one EXEC cycle. Timing from an accept at edge T:
- q holds its new value from edge T+2.
- done is high during the cycle after edge T+2.
- cmd_ready is high again from edge T+3.
REQ-018 CNT_UP with N>=1 SHALL occupy exactly N EXEC cycles, each incrementing q by 1. Bit i gets j=k=1 when all bits below i are 1; bit 0 always toggles.
REQ-019 CNT_DN SHALL mirror CNT_UP: each step decrements q by 1, and bit i toggles when all bits below i are 0.
REQ-020 An internal W-bit remaining-step counter SHALL be loaded with N at accept and decremented per step. EXEC -> DONE occurs on the step where the counter equals 1.
REQ-021 Counting SHALL wrap modulo 2^W (all-ones +1 -> 0; 0 -1 -> all-ones). wrap SHALL be a sticky flag, cleared at accept, set on any wrapping step, and presented with done.
REQ-022 wrap SHALL read 0 whenever done is low.

Reset
REQ-023 Asserting reset SHALL asynchronously force:
- state = IDLE, q = 0, remaining counter = 0, sticky wrap = 0.
- Outputs: busy = 0, done = 0, wrap = 0.
- cmd_ready = 1 once reset deasserts.
REQ-024 Reset asserted mid-command SHALL abort the command with no done pulse. The aborted command is not resumed.

Structure
REQ-025 A shared package jk_bank_pkg SHALL hold the opcode encodings, the FSM state type, and the default W.
REQ-026 The bank SHALL be W instances of sub-module jk_cell, a JK flip-flop with ports clk, reset (async active-low), j, k, q, qbar. jk_cell toggles on j=k=1 and never produces X.
REQ-027 The controller SHALL own all j/k generation; jk_cell SHALL contain no command logic.

Verification
REQ-028 Reset then LOAD arg=4'b1010 -> q=1010 at edge T+2; one-cycle done; wrap=0; cmd_ready high at T+3.
REQ-029 q=1101, CNT_UP N=5 -> 5 EXEC cycles; q sequence 1110, 1111, 0000, 0001, 0010; done with wrap=1.
REQ-030 q=0011, CNT_DN N=2 -> q=0001; wrap=0. Then CNT_DN N=0 -> done one cycle after accept; q=0001 unchanged.
REQ-031 cmd_valid held high with a CLEAR queued behind CNT_UP N=3 -> CLEAR accepted only after DONE returns to IDLE; q=0000 afterward.
REQ-032 Reset asserted during CNT_UP N=10 after step 4 -> q=0 immediately; no done; next LOAD 4'b0110 behaves per REQ-028.
